// File: rtl/sb_pkg.sv
// Sideband link constants and the framer state encoding shared by the
// transmit framer and the receive deframer.
package sb_pkg;

  localparam logic [7:0] SB_DLE     = 8'hFE;
  localparam logic [7:0] SB_STX_CMD = 8'h05;
  localparam logic [7:0] SB_STX_RSP = 8'h04;
  localparam logic [7:0] SB_ETX     = 8'h40;

  localparam int SYM_BITS = 10;  // start + 8 data + stop
  localparam int CRC_SYMS = 2;

  typedef enum logic [2:0] {
    IDLE, DLE1, STX, PAY, CRC, DLE2, ETX
  } sb_state_e;

endpackage

// File: rtl/sb_tx_framer_if.sv
// Transaction request and payload byte stream between the upper layer and
// the sideband transmit framer.
interface sb_tx_framer_if #(parameter int LEN_W = 6);
    logic             tx_start;
    logic             tx_rsp;
    logic [LEN_W-1:0] tx_len;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             busy;
    logic             done;
    logic             underrun;

    modport master (
        output tx_start, tx_rsp, tx_len, byte_in, byte_valid,
        input  byte_ready, busy, done, underrun
    );

    modport slave (
        input  tx_start, tx_rsp, tx_len, byte_in, byte_valid,
        output byte_ready, busy, done, underrun
    );
endinterface

// File: rtl/sb_sym_ser.sv
// Holds one byte and selects its start/data/stop bit for the current bit
// index, producing a 10-bit LSB-first symbol.
module sb_sym_ser import sb_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic [3:0] bit_cnt,
    output logic       ser_bit
);
    logic [7:0] shift_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    shift_byte <= '0;
        else if (load) shift_byte <= din;
    end

    always_comb begin
        ser_bit = 1'b1;
        if (bit_cnt == 4'd0)                    ser_bit = 1'b0;
        else if (bit_cnt <= 4'(SYM_BITS - 2))   ser_bit = shift_byte[3'(bit_cnt - 4'd1)];
    end
endmodule

// File: rtl/sb_tx_framer.sv
// Sideband transmit framer: emits DLE, STX, payload, CRC, DLE, ETX as serial
// symbols and steers the external serial CRC-16 block.
module sb_tx_framer import sb_pkg::*; #(
    parameter int         LEN_W    = 6,
    parameter logic [7:0] DLE_BYTE = SB_DLE,
    parameter logic [7:0] STX_CMD  = SB_STX_CMD,
    parameter logic [7:0] STX_RSP  = SB_STX_RSP,
    parameter logic [7:0] ETX_BYTE = SB_ETX
) (
    input  logic                 clk,
    input  logic                 reset,
    sb_tx_framer_if.slave        bus,
    input  logic                 crc_bit,
    output logic                 crc_enable,
    output logic                 crc_active,
    output logic                 crc_data,
    output logic                 sb_tx
);
    sb_state_e        state, nxt;
    logic [4:0]       bit_cnt;
    logic [LEN_W-1:0] remaining, len_q;
    logic             rsp_q, done_q, underrun_q;
    logic             last_bit, fetch, take, ld, ser_bit;
    logic [7:0]       ld_byte;

    assign last_bit = (state == CRC) ? (bit_cnt == 5'(SYM_BITS * CRC_SYMS - 1))
                                     : (bit_cnt == 5'(SYM_BITS - 1));
    assign fetch = (state == STX || state == PAY) && bit_cnt == 5'(SYM_BITS - 1)
                   && remaining != '0;
    assign take  = fetch && bus.byte_valid;

    always_comb begin
        nxt = IDLE;
        case (state)
            DLE1:    nxt = STX;
            STX:     nxt = (len_q != '0) ? PAY : CRC;
            PAY:     nxt = (remaining != '0) ? PAY : CRC;
            CRC:     nxt = DLE2;
            DLE2:    nxt = ETX;
            default: nxt = IDLE;
        endcase
    end

    // The serializer is reloaded on the last bit of each symbol so the next
    // state starts at bit 0 with its byte already in place.
    always_comb begin
        ld      = 1'b0;
        ld_byte = DLE_BYTE;
        if (state == IDLE) begin
            ld = bus.tx_start;
        end else if (take) begin
            ld      = 1'b1;
            ld_byte = bus.byte_in;
        end else if (last_bit) begin
            ld = (state == DLE1) || (state == CRC) || (state == DLE2);
            if (state == DLE1)      ld_byte = rsp_q ? STX_RSP : STX_CMD;
            else if (state == DLE2) ld_byte = ETX_BYTE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            remaining  <= '0;
            len_q      <= '0;
            rsp_q      <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (bus.tx_start) begin
                    state     <= DLE1;
                    rsp_q     <= bus.tx_rsp;
                    len_q     <= bus.tx_len;
                    remaining <= bus.tx_len;
                end
            end else if (fetch && !bus.byte_valid) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                underrun_q <= 1'b1;
            end else if (last_bit) begin
                state   <= nxt;
                bit_cnt <= '0;
                done_q  <= (state == ETX);
                if (take) remaining <= remaining - LEN_W'(1);
            end else begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    sb_sym_ser u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (ld),
        .din     (ld_byte),
        .bit_cnt (bit_cnt[3:0]),
        .ser_bit (ser_bit)
    );

    // The CRC block drives its own start/stop bits during the CRC symbols.
    always_comb begin
        sb_tx = ser_bit;
        if (state == IDLE)     sb_tx = 1'b1;
        else if (state == CRC) sb_tx = crc_bit;
    end

    assign crc_enable     = (state == STX) || (state == PAY) || (state == CRC);
    assign crc_active     = (state == CRC);
    assign crc_data       = (state == STX || state == PAY) ? sb_tx : 1'b0;
    assign bus.byte_ready = fetch;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_sb_tx_framer.sv
// Bench for sb_tx_framer with a behavioural serial CRC-16 block beside it and
// a per-cycle scoreboard of the expected line/control outputs.
module tb_sb_tx_framer;
    localparam int LEN_W = 6;

    logic clk = 1'b0;
    logic reset;
    logic crc_bit, crc_enable, crc_active, crc_data, sb_tx;
    sb_tx_framer_if #(.LEN_W(LEN_W)) bus();

    sb_tx_framer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .crc_bit(crc_bit),
        .crc_enable(crc_enable), .crc_active(crc_active),
        .crc_data(crc_data), .sb_tx(sb_tx)
    );

    always #5 clk = ~clk;

    // Serial CRC-16 (poly 8005, init FFFF) over data bits 1..8 of each symbol;
    // in active mode it shifts the remainder out MSB first with start/stop.
    logic [15:0] crc_q;
    logic [3:0]  ccnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= 16'hFFFF; ccnt <= 4'd0;
        end else if (!crc_enable) begin
            crc_q <= 16'hFFFF; ccnt <= 4'd0;
        end else begin
            ccnt <= (ccnt == 4'd9) ? 4'd0 : ccnt + 4'd1;
            if (ccnt >= 4'd1 && ccnt <= 4'd8)
                crc_q <= crc_active ? {crc_q[14:0], 1'b0}
                       : ({crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ crc_data) ? 16'h8005 : 16'h0000));
        end
    end
    assign crc_bit = !crc_active ? 1'b1 : (ccnt == 4'd0) ? 1'b0 : (ccnt == 4'd9) ? 1'b1 : crc_q[15];

    int n_cmp = 0, n_err = 0;
    logic [6:0] exp_q[$];
    logic [6:0] mon_e, mon_a;
    logic [7:0] pay [0:3];
    logic cap [0:255], rdy [0:255], dn [0:255], ur [0:255];

    // {sb_tx, crc_enable, crc_active, byte_ready, busy, done, underrun}
    function automatic logic [6:0] ent(logic tx, logic en, logic act, logic rd,
                                       logic bs, logic d, logic u);
        return {tx, en, act, rd, bs, d, u};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {sb_tx, crc_enable, crc_active, bus.byte_ready, bus.busy, bus.done, bus.underrun};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL stream t=%0t got=%b exp=%b", $time, mon_a, mon_e);
            end
        end
    end

    function automatic logic [15:0] crc_ref(logic [7:0] stx, int len);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i <= len; i++) begin
            b = (i == 0) ? stx : pay[i-1];
            for (int k = 0; k < 8; k++)
                c = {c[14:0], 1'b0} ^ ((c[15] ^ b[k]) ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    task automatic push_sym(input logic [7:0] b, input logic en, input logic rd);
        for (int i = 0; i < 10; i++)
            exp_q.push_back(ent((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1], en, 1'b0,
                                rd && i == 9, 1'b1, 1'b0, 1'b0));
    endtask

    // ur_at: fetch index at which byte_valid is withheld (-1 = never).
    task automatic exp_frame(input logic rsp, input int len, input int ur_at);
        logic [15:0] c;
        logic [7:0]  stx;
        int j;
        stx = rsp ? 8'h04 : 8'h05;
        push_sym(8'hFE, 1'b0, 1'b0);
        push_sym(stx, 1'b1, len > 0);
        for (int i = 0; i < len; i++) begin
            push_sym(pay[i], 1'b1, i < len - 1);
            if (ur_at == i + 1) begin
                exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 1));
                exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 0));
                return;
            end
        end
        c = crc_ref(stx, len);
        for (int k = 0; k < 20; k++) begin
            j = k % 10;
            exp_q.push_back(ent((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : c[15 - 8*(k/10) - (j-1)],
                                1, 1, 0, 1, 0, 0));
        end
        push_sym(8'hFE, 1'b0, 1'b0);
        push_sym(8'h40, 1'b0, 1'b0);
        exp_q.push_back(ent(1, 0, 0, 0, 0, 1, 0));
    endtask

    // Starts a transaction, feeds payload bytes and records the line per cycle
    // (cycle 0 = first DLE1 bit). rst_at asserts reset at that cycle and returns.
    task automatic run_tx(input logic rsp, input int len, input bit hold, input int ncyc,
                          input int ur_fetch, input int rst_at);
        int fi, nf;
        bit took;
        logic [6:0] drop;
        @(negedge clk);
        bus.tx_start = 1'b1; bus.tx_rsp = rsp; bus.tx_len = LEN_W'(len);
        bus.byte_valid = 1'b1; bus.byte_in = pay[0];
        fi = 0; nf = 0; took = 1'b0;
        @(posedge clk); #1;
        exp_frame(rsp, len, ur_fetch);
        if (hold) exp_frame(rsp, len, ur_fetch);
        if (rst_at >= 0) while (exp_q.size() > rst_at) drop = exp_q.pop_back();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                reset = 1'b0;
                return;
            end
            if (!hold || c == 61 + 10*len) bus.tx_start = 1'b0;
            if (took) begin fi++; bus.byte_in = pay[fi % len]; took = 1'b0; end
            cap[c] = sb_tx; rdy[c] = bus.byte_ready; dn[c] = bus.done; ur[c] = bus.underrun;
            if (bus.byte_ready) begin
                if (nf == ur_fetch) bus.byte_valid = 1'b0;
                nf++;
                took = bus.byte_valid;
            end
        end
    endtask

    function automatic logic [9:0] sym_at(int base);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = cap[base + i];
        return v;
    endfunction

    task automatic test_reset();
        logic [7:0] a;
        #12;
        a = {sb_tx, bus.byte_ready, crc_enable, crc_active, crc_data, bus.busy, bus.done, bus.underrun};
        n_cmp++;
        if (a !== 8'b1000_0000) begin n_err++; $display("FAIL reset_vals got=%b exp=%b", a, 8'b1000_0000); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        repeat (20) exp_q.push_back(ent(1, 0, 0, 0, 0, 0, 0));
        repeat (21) @(negedge clk);
    endtask

    task automatic test_cmd_empty();
        int nd;
        run_tx(1'b0, 0, 1'b0, 62, -1, -1);
        n_cmp++; if (sym_at(0) !== 10'h3FC) begin n_err++; $display("FAIL dle1_bits got=%h exp=3fc", sym_at(0)); end
        n_cmp++; if (sym_at(10) !== 10'h20A) begin n_err++; $display("FAIL stx_bits got=%h exp=20a", sym_at(10)); end
        n_cmp++; if (sym_at(50) !== 10'h280) begin n_err++; $display("FAIL etx_bits got=%h exp=280", sym_at(50)); end
        nd = 0;
        for (int c = 0; c < 62; c++) nd += int'(dn[c]);
        n_cmp++; if (dn[60] !== 1'b1 || nd != 1) begin n_err++; $display("FAIL done_pulse got=%b/%0d exp=1/1", dn[60], nd); end
    endtask

    task automatic test_payload();
        int nr;
        pay[0] = 8'h01; pay[1] = 8'h80; pay[2] = 8'hA5;
        run_tx(1'b0, 3, 1'b0, 92, -1, -1);
        nr = 0;
        for (int c = 0; c < 92; c++) nr += int'(rdy[c]);
        n_cmp++;
        if (!(rdy[19] && rdy[29] && rdy[39]) || nr != 3) begin
            n_err++; $display("FAIL ready_cycles got=%b%b%b/%0d exp=111/3", rdy[19], rdy[29], rdy[39], nr);
        end
        n_cmp++; if (sym_at(20) !== 10'h202) begin n_err++; $display("FAIL pay0 got=%h exp=202", sym_at(20)); end
        n_cmp++; if (sym_at(30) !== 10'h300) begin n_err++; $display("FAIL pay1 got=%h exp=300", sym_at(30)); end
        n_cmp++; if (sym_at(40) !== 10'h34A) begin n_err++; $display("FAIL pay2 got=%h exp=34a", sym_at(40)); end
        n_cmp++; if (dn[90] !== 1'b1) begin n_err++; $display("FAIL done_len3 got=%b exp=1", dn[90]); end
    endtask

    task automatic test_rsp();
        pay[0] = 8'h3C;
        run_tx(1'b1, 1, 1'b0, 72, -1, -1);
        n_cmp++; if (sym_at(10) !== 10'h208) begin n_err++; $display("FAIL stx_rsp got=%h exp=208", sym_at(10)); end
    endtask

    task automatic test_underrun();
        int nd, nu;
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_tx(1'b0, 2, 1'b0, 40, 1, -1);
        nd = 0; nu = 0;
        for (int c = 0; c < 40; c++) begin nd += int'(dn[c]); nu += int'(ur[c]); end
        n_cmp++;
        if (ur[30] !== 1'b1 || nu != 1 || nd != 0) begin
            n_err++; $display("FAIL underrun got=%b/%0d done=%0d exp=1/1 done=0", ur[30], nu, nd);
        end
        n_cmp++; if (cap[30] !== 1'b1) begin n_err++; $display("FAIL underrun_line got=%b exp=1", cap[30]); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] c1, c2;
        pay[0] = 8'h3C; pay[1] = 8'h5A;
        run_tx(1'b0, 2, 1'b1, 163, -1, -1);
        // Frame is 80 bits; done/idle bit at 80, second DLE1 start at 81.
        n_cmp++;
        if ({cap[79], cap[80], cap[81]} !== 3'b110 || dn[80] !== 1'b1 || dn[161] !== 1'b1) begin
            n_err++; $display("FAIL b2b_gap got=%b%b%b done=%b%b exp=110 done=11",
                              cap[79], cap[80], cap[81], dn[80], dn[161]);
        end
        for (int i = 0; i < 20; i++) begin c1[i] = cap[40 + i]; c2[i] = cap[121 + i]; end
        n_cmp++; if (c2 !== c1) begin n_err++; $display("FAIL b2b_crc got=%h exp=%h", c2, c1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        run_tx(1'b0, 0, 1'b0, 40, -1, 27);
        #1;
        a = {sb_tx, bus.byte_ready, crc_enable, crc_active, crc_data, bus.busy, bus.done, bus.underrun};
        n_cmp++;
        if (a !== 8'b1000_0000) begin n_err++; $display("FAIL mid_reset got=%b exp=%b", a, 8'b1000_0000); end
        @(negedge clk); reset = 1'b1;
        pay[0] = 8'hC3;
        run_tx(1'b0, 1, 1'b0, 72, -1, -1);
    endtask

    initial begin
        reset = 1'b0;
        bus.tx_start = 1'b0; bus.tx_rsp = 1'b0; bus.tx_len = '0;
        bus.byte_in = '0; bus.byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) pay[i] = 8'h00;
        test_reset();
        test_cmd_empty();
        test_payload();
        test_rsp();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
